// File: rtl/vseq_load_aligner.sv
// vseq_load_aligner
//   Sits between the AXI R channel and the vector shuffle unit. For each
//   unit-stride load command it strips the start-address misalignment from
//   the incoming bus beats and repacks the bytes into zero-based sequential
//   words. Each word goes out as nibble data plus per-nibble enables.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   cmd_valid_i/ready_o     command handshake into a CmdDepth-entry FIFO
//   cmd_offset_i            byte offset of the first valid byte in beat 0
//   cmd_nbytes_i            bytes to deliver (>0)
//   r_valid_i/ready_o       read-data beat handshake
//   r_data_i, r_last_i      beat data (byte 0 at LSB) and burst-last flag
//   tx_valid_o/ready_i      sequential word handshake toward the shuffle stage
//   tx_nb_o, tx_en_o        word nibbles and per-nibble enables
//   busy_o                  command active, queued, or output word pending
//   err_last_o              one-cycle pulse when r_last_i disagrees with beat count
module vseq_load_aligner #(
  parameter int BusBytes = 32,
  parameter int LenBits  = 16,
  parameter int CmdDepth = 2,
  parameter int OffBits  = $clog2(BusBytes)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [OffBits-1:0]    cmd_offset_i,
  input  logic [LenBits-1:0]    cmd_nbytes_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic [BusBytes*8-1:0] r_data_i,
  input  logic                  r_last_i,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [BusBytes*8-1:0] tx_nb_o,
  output logic [BusBytes*2-1:0] tx_en_o,
  output logic                  busy_o,
  output logic                  err_last_o
);

  localparam int PtrW  = (CmdDepth > 1) ? $clog2(CmdDepth) : 1;
  localparam int CntW  = LenBits + 1;
  localparam int EcW   = OffBits + 1;
  localparam int DataW = BusBytes * 8;
  localparam int NibW  = BusBytes * 2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  // ---------------------------------------------------------------------
  // Command FIFO. The head stays in the FIFO while it is the active
  // command and is popped only when that command completes.
  // ---------------------------------------------------------------------
  logic [OffBits-1:0] fifo_off_q [CmdDepth];
  logic [OffBits-1:0] fifo_off_d [CmdDepth];
  logic [LenBits-1:0] fifo_nb_q  [CmdDepth];
  logic [LenBits-1:0] fifo_nb_d  [CmdDepth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt, ld_ptr;
  logic [PtrW:0]      cnt_q, cnt_d;
  logic               push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(CmdDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Popping frees a slot this cycle, so a full FIFO can still take a command.
  assign cmd_ready_o = (cnt_q != (PtrW+1)'(CmdDepth)) || pop;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign rd_nxt      = ptr_inc(rd_ptr_q);

  always_comb begin
    fifo_off_d = fifo_off_q;
    fifo_nb_d  = fifo_nb_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
    if (push) begin
      fifo_off_d[wr_ptr_q] = cmd_offset_i;
      fifo_nb_d[wr_ptr_q]  = cmd_nbytes_i;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = rd_nxt;
  end

  // ---------------------------------------------------------------------
  // Active command and datapath state
  // ---------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [OffBits-1:0]  off_q, off_d;
  logic [CntW-1:0]     rbeats_q, rbeats_d;
  logic [CntW-1:0]     bytes_left_q, bytes_left_d;
  logic [CntW-1:0]     beat_idx_q, beat_idx_d;
  logic [DataW-1:0]    carry_q, carry_d;
  logic                carry_vld_q, carry_vld_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DataW-1:0]    tx_nb_q, tx_nb_d;
  logic [NibW-1:0]     tx_en_q, tx_en_d;
  logic                err_q, err_d;

  // Load path: from IDLE the head is loaded; at completion the entry behind
  // the head is loaded so the next command runs without an IDLE bubble.
  logic [OffBits-1:0]  ld_off;
  logic [LenBits-1:0]  ld_nb;
  logic [CntW-1:0]     rbeats_ld;

  assign ld_ptr    = (state_q == IDLE) ? rd_ptr_q : rd_nxt;
  assign ld_off    = fifo_off_q[ld_ptr];
  assign ld_nb     = fifo_nb_q[ld_ptr];
  assign rbeats_ld = (CntW'(ld_off) + CntW'(ld_nb) + CntW'(BusBytes - 1)) >> OffBits;

  // Beat alignment: beat_hi brings bytes [BusBytes-1:off] down to byte 0
  // (the new carry); beat_lo lifts bytes [off-1:0] up above the carry.
  logic [OffBits-1:0]  inv_off;
  logic [DataW-1:0]    beat_hi, beat_lo;

  assign inv_off = OffBits'(BusBytes) - off_q;
  assign beat_hi = r_data_i >> {off_q, 3'b000};
  assign beat_lo = r_data_i << {inv_off, 3'b000};

  // Bytes carried by the next emitted word.
  logic [EcW-1:0]      emit_cnt;
  assign emit_cnt = (bytes_left_q >= CntW'(BusBytes)) ? EcW'(BusBytes)
                                                     : bytes_left_q[EcW-1:0];

  logic [BusBytes-1:0] byte_on;
  logic [DataW-1:0]    data_mask;
  logic [NibW-1:0]     nib_en;

  for (genvar b = 0; b < BusBytes; b++) begin : g_byte
    assign byte_on[b]          = (EcW'(b) < emit_cnt);
    assign nib_en[2*b +: 2]    = {2{byte_on[b]}};
    assign data_mask[8*b +: 8] = {8{byte_on[b]}};
  end

  logic             tx_space, r_fire, last_beat, emit, done, load;
  logic [DataW-1:0] emit_word;

  assign tx_space  = !tx_valid_q || tx_ready_i;
  assign r_ready_o = (state_q == RUN) && tx_space;
  assign r_fire    = r_ready_o && r_valid_i;
  assign last_beat = (beat_idx_q == rbeats_q - CntW'(1));

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    rbeats_d     = rbeats_q;
    bytes_left_d = bytes_left_q;
    beat_idx_d   = beat_idx_q;
    carry_d      = carry_q;
    carry_vld_d  = carry_vld_q;
    tx_valid_d   = tx_valid_q;
    tx_nb_d      = tx_nb_q;
    tx_en_d      = tx_en_q;
    err_d        = 1'b0;
    emit         = 1'b0;
    emit_word    = '0;
    done         = 1'b0;
    load         = 1'b0;
    pop          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) load = 1'b1;
      end
      RUN: begin
        if (r_fire) begin
          beat_idx_d = beat_idx_q + CntW'(1);
          // Beat count is authoritative; r_last only raises a flag.
          err_d      = (r_last_i != last_beat);
          if (off_q == '0) begin
            emit      = 1'b1;
            emit_word = r_data_i;
          end else if (!carry_vld_q) begin
            carry_d     = beat_hi;
            carry_vld_d = 1'b1;
            // Single-beat burst: the carry is the whole payload.
            if (last_beat) begin
              emit      = 1'b1;
              emit_word = beat_hi;
            end
          end else begin
            emit      = 1'b1;
            emit_word = beat_lo | carry_q;
            carry_d   = beat_hi;
          end
          done = emit && (bytes_left_q <= CntW'(BusBytes));
          if (last_beat && !done) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Only reached with fewer than BusBytes bytes left, all in carry.
        if (tx_space) begin
          emit      = 1'b1;
          emit_word = carry_q;
          done      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      bytes_left_d = bytes_left_q - CntW'(emit_cnt);
      tx_valid_d   = 1'b1;
      tx_nb_d      = emit_word & data_mask;
      tx_en_d      = nib_en;
    end else if (tx_ready_i) begin
      tx_valid_d = 1'b0;
    end

    if (done) begin
      pop         = 1'b1;
      carry_vld_d = 1'b0;
      if (cnt_q > (PtrW+1)'(1)) load = 1'b1;
      else                      state_d = IDLE;
    end

    if (load) begin
      off_d        = ld_off;
      rbeats_d     = rbeats_ld;
      bytes_left_d = CntW'(ld_nb);
      beat_idx_d   = '0;
      carry_vld_d  = 1'b0;
      state_d      = RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CmdDepth; i++) begin
        fifo_off_q[i] <= '0;
        fifo_nb_q[i]  <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      off_q        <= '0;
      rbeats_q     <= '0;
      bytes_left_q <= '0;
      beat_idx_q   <= '0;
      carry_q      <= '0;
      carry_vld_q  <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_nb_q      <= '0;
      tx_en_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      fifo_off_q   <= fifo_off_d;
      fifo_nb_q    <= fifo_nb_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      off_q        <= off_d;
      rbeats_q     <= rbeats_d;
      bytes_left_q <= bytes_left_d;
      beat_idx_q   <= beat_idx_d;
      carry_q      <= carry_d;
      carry_vld_q  <= carry_vld_d;
      tx_valid_q   <= tx_valid_d;
      tx_nb_q      <= tx_nb_d;
      tx_en_q      <= tx_en_d;
      err_q        <= err_d;
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_nb_o    = tx_nb_q;
  assign tx_en_o    = tx_en_q;
  assign err_last_o = err_q;
  assign busy_o     = (state_q != IDLE) || tx_valid_q || (cnt_q != '0);

endmodule

// File: tb/tb_vseq_load_aligner.sv
// Directed bench for vseq_load_aligner (BusBytes=32). Beat k carries byte
// value (b + 32*k) mod 256 at byte b, so sequential output byte i of word w
// must equal (offset + 32*w + i) mod 256.
module tb_vseq_load_aligner;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [4:0]   cmd_off = '0;
  logic [15:0]  cmd_nb = '0;
  logic         r_valid = 1'b0;
  logic         r_ready;
  logic [255:0] r_data = '0;
  logic         r_last = 1'b0;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic [255:0] tx_nb;
  logic [63:0]  tx_en;
  logic         busy;
  logic         err_last;

  int n_chk = 0;
  int n_err = 0;
  int err_pulses = 0;
  logic [255:0] q_nb[$];
  logic [63:0]  q_en[$];

  typedef struct {
    int off;
    int nb;
    int beats;
    int words;
    int last_cnt;
  } vec_t;
  vec_t vecs[10];

  vseq_load_aligner #(.BusBytes(32), .LenBits(16), .CmdDepth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_offset_i(cmd_off), .cmd_nbytes_i(cmd_nb),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_last_i(r_last),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_nb_o(tx_nb), .tx_en_o(tx_en),
    .busy_o(busy), .err_last_o(err_last)
  );

  always #5 clk = ~clk;

  // Output collector: a word is taken at the next rising edge.
  always @(negedge clk) begin
    #1;
    if (rst_n && tx_valid && tx_ready) begin
      q_nb.push_back(tx_nb);
      q_en.push_back(tx_en);
    end
    if (rst_n && err_last) err_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] beat(input int k);
    logic [255:0] d;
    for (int b = 0; b < 32; b++) d[8*b +: 8] = 8'((b + 32*k) % 256);
    return d;
  endfunction

  function automatic logic [255:0] exp_nb(input int first, input int w, input int cnt);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 32; i++)
      if (i < cnt) d[8*i +: 8] = 8'((first + 32*w + i) % 256);
    return d;
  endfunction

  function automatic logic [63:0] exp_en(input int cnt);
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < 32; i++)
      if (i < cnt) e[2*i +: 2] = 2'b11;
    return e;
  endfunction

  // Leaves cmd_valid high; the caller drops it.
  task automatic push_cmd(input int off, input int nb);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_off   = 5'(off);
    cmd_nb    = 16'(nb);
    #1;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); #1; t++; end
    if (!cmd_ready) begin
      n_chk++; n_err++;
      $display("FAIL cmd_push: got cmd_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
  endtask

  task automatic drive_beats(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      r_valid = 1'b1;
      r_data  = beat(k);
      r_last  = (k == n - 1);
      #1;
      t = 0;
      while (!r_ready && t < 200) begin @(negedge clk); #1; t++; end
      if (!r_ready) begin
        n_chk++; n_err++;
        $display("FAIL beat_accept: got r_ready=0 expected 1 within 200 cycles");
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    r_valid = 1'b0;
    r_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    @(negedge clk); #1;
    t = 0;
    while (busy && t < 300) begin @(negedge clk); #1; t++; end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_words(input string tag, input int first, input int words, input int last_cnt);
    int cnt;
    chk({tag, "_nwords"}, q_nb.size(), words);
    for (int w = 0; w < words && w < q_nb.size(); w++) begin
      cnt = (w == words - 1) ? last_cnt : 32;
      chk($sformatf("%s_w%0d_nb", tag, w), q_nb[w], exp_nb(first, w, cnt));
      chk($sformatf("%s_w%0d_en", tag, w), q_en[w], exp_en(cnt));
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    q_nb.delete(); q_en.delete();
    err_pulses = 0;
    push_cmd(v.off, v.nb);
    @(negedge clk);
    cmd_valid = 1'b0;
    drive_beats(v.beats);
    wait_idle(tag);
    check_words(tag, v.off, v.words, v.last_cnt);
    chk({tag, "_err"}, err_pulses, 0);
  endtask

  initial begin
    int t;
    //           off  nb beats words last
    vecs[0] = '{ 0,  64, 2, 2, 32};  // aligned, two full beats
    vecs[1] = '{ 4,  64, 3, 2, 32};  // misaligned, ends exactly on a beat
    vecs[2] = '{ 8,  10, 1, 1, 10};  // single-beat partial word
    vecs[3] = '{ 4,  60, 2, 2, 28};  // residual carry via FLUSH
    vecs[4] = '{31,   2, 2, 1,  2};  // one byte per beat
    vecs[5] = '{ 0,  96, 3, 3, 32};
    vecs[6] = '{16,  16, 1, 1, 16};
    vecs[7] = '{ 0,   1, 1, 1,  1};  // minimum length
    vecs[8] = '{ 1,  63, 2, 2, 31};  // 31-byte flush
    vecs[9] = '{31,  33, 2, 2,  1};  // 1-byte flush

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_nb", tx_nb, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_last, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Output backpressure: hold tx_ready low for 5 cycles after word 0.
    q_nb.delete(); q_en.delete();
    tx_ready = 1'b0;
    push_cmd(0, 96);
    @(negedge clk);
    cmd_valid = 1'b0;
    fork
      drive_beats(3);
      begin
        int tw;
        @(negedge clk); #1;
        tw = 0;
        while (!tx_valid && tw < 100) begin @(negedge clk); #1; tw++; end
        chk("bp_first_valid", tx_valid, 1);
        for (int c = 0; c < 5; c++) begin
          chk($sformatf("bp_hold%0d_nb", c), tx_nb, exp_nb(0, 0, 32));
          chk($sformatf("bp_hold%0d_valid", c), tx_valid, 1);
          chk($sformatf("bp_hold%0d_rready", c), r_ready, 0);
          @(negedge clk);
          if (c < 4) #1;
        end
        tx_ready = 1'b1;
      end
    join
    wait_idle("bp");
    check_words("bp", 0, 3, 32);

    // Back-to-back commands fill the two-entry FIFO.
    q_nb.delete(); q_en.delete();
    push_cmd(0, 32);
    push_cmd(16, 16);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("b2b_full_ready", cmd_ready, 0);
    chk("b2b_busy", busy, 1);
    drive_beats(1);
    drive_beats(1);
    wait_idle("b2b");
    chk("b2b_nwords", q_nb.size(), 2);
    if (q_nb.size() == 2) begin
      chk("b2b_w0_nb", q_nb[0], exp_nb(0, 0, 32));
      chk("b2b_w0_en", q_en[0], exp_en(32));
      chk("b2b_w1_nb", q_nb[1], exp_nb(16, 0, 16));
      chk("b2b_w1_en", q_en[1], 64'h0000_0000_FFFF_FFFF);
    end
    chk("b2b_ready_after", cmd_ready, 1);

    // Early r_last, then asynchronous reset mid-burst.
    tx_ready = 1'b0;
    push_cmd(0, 64);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    r_valid = 1'b1;
    r_data  = beat(0);
    r_last  = 1'b1;
    #1;
    t = 0;
    while (!r_ready && t < 50) begin @(negedge clk); #1; t++; end
    chk("el_rready", r_ready, 1);
    @(posedge clk);
    @(negedge clk);
    r_valid = 1'b0;
    r_last  = 1'b0;
    #1;
    chk("el_err_pulse", err_last, 1);
    chk("el_tx_valid", tx_valid, 1);
    chk("el_word0", tx_nb, exp_nb(0, 0, 32));
    @(negedge clk); #1;
    chk("el_err_single", err_last, 0);
    chk("el_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tx_valid", tx_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_tx_en", tx_en, 0);
    chk("ar_tx_nb", tx_nb, 0);
    chk("ar_r_ready", r_ready, 0);
    chk("ar_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    run_vec(vecs[2], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
